// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared FSM states, register-address width and control-bundle encodings for the pipeline controller.
package pipeline_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_bubble;
  } ctrl_t;
  localparam ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
endpackage

// File: rtl/pipeline_ctrl_hazard_cmp.sv
// hazard_cmp: combinational load-use detector; x0 never creates a dependency.
module hazard_cmp
  import pipeline_pkg::*;
(
  input  logic                  i_memread,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1,
  input  logic [REG_ADDR_W-1:0] i_rs2,
  input  logic                  i_use_rs1,
  input  logic                  i_use_rs2,
  output logic                  o_hazard
);
  assign o_hazard = i_memread && (i_rd != '0) &&
                    ((i_use_rs1 && (i_rs1 == i_rd)) || (i_use_rs2 && (i_rs2 == i_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller resolving load-use, taken-branch and multi-cycle memory hazards.
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  idex_memread_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs1_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs2_i,
  input  logic                  ifid_use_rs1_i,
  input  logic                  ifid_use_rs2_i,
  input  logic                  branch_taken_i,
  input  logic                  exmem_memreq_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_en_o,
  output logic                  ifid_en_o,
  output logic                  idex_en_o,
  output logic                  exmem_en_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  memwb_bubble_o,
  output logic [1:0]            state_o,
  output logic                  err_o,
  output logic [CNT_W-1:0]      stall_cnt_o
);
  state_e            r_state;
  logic [7:0]        r_wait_cnt;
  logic              r_err;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_lu;
  logic              w_ms;
  ctrl_t             w_release;
  ctrl_t             w_ctrl;

  hazard_cmp u_hazard_cmp (
    .i_memread (idex_memread_i),
    .i_rd      (idex_rd_i),
    .i_rs1     (ifid_rs1_i),
    .i_rs2     (ifid_rs2_i),
    .i_use_rs1 (ifid_use_rs1_i),
    .i_use_rs2 (ifid_use_rs2_i),
    .o_hazard  (w_lu)
  );

  // MEM_WAIT with ready decodes exactly like RUN without a memory stall.
  always_comb begin
    w_ms      = exmem_memreq_i && !dmem_ready_i;
    w_release = branch_taken_i ? CTRL_BRANCH : w_lu ? CTRL_LU : CTRL_RUN;
    w_ctrl    = rst_n                     ? CTRL_RESET  :
                (r_state == ST_ERR)       ? CTRL_FREEZE :
                (r_state == ST_MEM_WAIT)  ? (dmem_ready_i ? w_release : CTRL_FREEZE) :
                w_ms                      ? CTRL_FREEZE : w_release;
  end

  assign pc_en_o        = w_ctrl.pc_en;
  assign ifid_en_o      = w_ctrl.ifid_en;
  assign idex_en_o      = w_ctrl.idex_en;
  assign exmem_en_o     = w_ctrl.exmem_en;
  assign ifid_flush_o   = w_ctrl.ifid_flush;
  assign idex_flush_o   = w_ctrl.idex_flush;
  assign memwb_bubble_o = w_ctrl.memwb_bubble;
  assign state_o        = r_state;
  assign err_o          = r_err;
  assign stall_cnt_o    = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (!w_ctrl.pc_en && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      case (r_state)
        ST_MEM_WAIT: begin
          if (dmem_ready_i) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
          end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
            r_state <= ST_ERR;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        ST_ERR: r_state <= ST_ERR;
        default: begin
          r_state    <= w_ms ? ST_MEM_WAIT : ST_RUN;
          r_wait_cnt <= w_ms ? 8'd1 : '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed checks of hazard decode, memory wait, timeout, saturation and reset.
module tb_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       idex_memread_i;
  logic [4:0] idex_rd_i, ifid_rs1_i, ifid_rs2_i;
  logic       ifid_use_rs1_i, ifid_use_rs2_i;
  logic       branch_taken_i, exmem_memreq_i, dmem_ready_i;
  logic       pc_en_o, ifid_en_o, idex_en_o, exmem_en_o;
  logic       ifid_flush_o, idex_flush_o, memwb_bubble_o;
  logic [1:0] state_o;
  logic       err_o;
  logic [3:0] stall_cnt_o;
  logic [6:0] ctrl;
  int         n_tests = 0;
  int         n_fail = 0;

  localparam logic [6:0] C_RUN = 7'b1111_000;
  localparam logic [6:0] C_BR  = 7'b1111_110;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_RST = 7'b0000_111;

  always #5 clk = ~clk;

  assign ctrl = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, ifid_flush_o, idex_flush_o, memwb_bubble_o};

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .idex_memread_i (idex_memread_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs1_i     (ifid_rs1_i),
    .ifid_rs2_i     (ifid_rs2_i),
    .ifid_use_rs1_i (ifid_use_rs1_i),
    .ifid_use_rs2_i (ifid_use_rs2_i),
    .branch_taken_i (branch_taken_i),
    .exmem_memreq_i (exmem_memreq_i),
    .dmem_ready_i   (dmem_ready_i),
    .pc_en_o        (pc_en_o),
    .ifid_en_o      (ifid_en_o),
    .idex_en_o      (idex_en_o),
    .exmem_en_o     (exmem_en_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_flush_o   (idex_flush_o),
    .memwb_bubble_o (memwb_bubble_o),
    .state_o        (state_o),
    .err_o          (err_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_memread_i = 0; idex_rd_i = 0; ifid_rs1_i = 0; ifid_rs2_i = 0;
    ifid_use_rs1_i = 0; ifid_use_rs2_i = 0; branch_taken_i = 0;
    exmem_memreq_i = 0; dmem_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 1;
    tick();
    rst_n = 0;
    idle();
    #1;
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    idex_memread_i = 1; idex_rd_i = rd; ifid_rs1_i = rs1; ifid_rs2_i = rs2;
    ifid_use_rs1_i = u1; ifid_use_rs2_i = u2;
  endtask

  initial begin
    idle();
    rst_n = 1;
    #2;
    chk("reset_ctrl", 32'(ctrl), 32'(C_RST));
    tick();
    rst_n = 0;
    #1;
    chk("post_reset_state", 32'(state_o), 0);
    chk("post_reset_err", 32'(err_o), 0);
    chk("post_reset_cnt", 32'(stall_cnt_o), 0);
    chk("normal_ctrl", 32'(ctrl), 32'(C_RUN));
    // load-use on rs1: one stall cycle, then the load has moved on
    set_lu(5, 5, 0, 1, 0);
    #1 chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
    tick();
    idle();
    #1 chk("lu_after_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("lu_cnt", 32'(stall_cnt_o), 1);
    // x0 and unused sources never stall
    set_lu(0, 0, 0, 1, 1);
    #1 chk("lu_x0", 32'(ctrl), 32'(C_RUN));
    set_lu(7, 3, 7, 1, 0);
    #1 chk("lu_rs2_unused", 32'(ctrl), 32'(C_RUN));
    set_lu(7, 3, 7, 1, 1);
    #1 chk("lu_rs2_used", 32'(ctrl), 32'(C_LU));
    set_lu(7, 7, 3, 0, 1);
    #1 chk("lu_rs1_unused", 32'(ctrl), 32'(C_RUN));
    // branch overrides load-use
    set_lu(9, 9, 9, 1, 1);
    branch_taken_i = 1;
    #1 chk("branch_over_lu", 32'(ctrl), 32'(C_BR));
    idle();
    do_reset();
    // memory wait: 3 frozen cycles then same-cycle release
    exmem_memreq_i = 1;
    #1 chk("ms_run_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("ms_run_state", 32'(state_o), 0);
    tick();
    chk("mw1_state", 32'(state_o), 1);
    chk("mw1_ctrl", 32'(ctrl), 32'(C_FRZ));
    tick();
    chk("mw2_ctrl", 32'(ctrl), 32'(C_FRZ));
    tick();
    dmem_ready_i = 1;
    #1 chk("mw_release_ctrl", 32'(ctrl), 32'(C_RUN));
    chk("mw_release_state", 32'(state_o), 1);
    chk("mw_cnt", 32'(stall_cnt_o), 3);
    tick();
    idle();
    #1 chk("mw_back_run", 32'(state_o), 0);
    chk("mw_cnt_hold", 32'(stall_cnt_o), 3);
    do_reset();
    // branch held through MEM_WAIT acts in the release cycle
    exmem_memreq_i = 1;
    branch_taken_i = 1;
    #1 chk("ms_over_branch", 32'(ctrl), 32'(C_FRZ));
    tick();
    dmem_ready_i = 1;
    #1 chk("release_branch", 32'(ctrl), 32'(C_BR));
    tick();
    idle();
    do_reset();
    // timeout: MEM_TIMEOUT=4, ERR after the 4th wait cycle
    exmem_memreq_i = 1;
    for (int i = 0; i < 4; i++) tick();
    chk("to_wait4_state", 32'(state_o), 1);
    chk("to_wait4_err", 32'(err_o), 0);
    tick();
    chk("to_err_state", 32'(state_o), 2);
    chk("to_err_flag", 32'(err_o), 1);
    chk("to_err_ctrl", 32'(ctrl), 32'(C_FRZ));
    chk("to_err_cnt", 32'(stall_cnt_o), 5);
    dmem_ready_i = 1;
    #1 chk("err_late_ready_ctrl", 32'(ctrl), 32'(C_FRZ));
    tick();
    chk("err_late_ready_state", 32'(state_o), 2);
    chk("err_cnt6", 32'(stall_cnt_o), 6);
    // saturation of the 4-bit counter
    for (int i = 0; i < 15; i++) tick();
    chk("cnt_saturate", 32'(stall_cnt_o), 15);
    rst_n = 1;
    #1 chk("rst_in_err_ctrl", 32'(ctrl), 32'(C_RST));
    chk("rst_in_err_state", 32'(state_o), 2);
    tick();
    rst_n = 0;
    idle();
    #1 chk("rst_clr_state", 32'(state_o), 0);
    chk("rst_clr_err", 32'(err_o), 0);
    chk("rst_clr_cnt", 32'(stall_cnt_o), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It resolves three conditions:
- load-use hazards in ID;
- taken branches resolved in EX;
- multi-cycle data-memory accesses in MEM.

From these it drives the enable/flush inputs of the PC, IFID, IDEX and EXMEM registers, plus a bubble input on MEMWB that forces its latched RegWrite to 0. It also holds a memory-wait FSM with timeout, and a saturating stall-cycle counter for performance debug.

## Interface
- MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before entering ERR (1..255)
- CNT_W, 16, stall counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-high (1 = reset)
- idex_memread_i  in  1  instruction in EX is a load
- idex_rd_i  in  5  destination register of instruction in EX
- ifid_rs1_i, ifid_rs2_i  in  5 each  source registers of instruction in ID
- ifid_use_rs1_i, ifid_use_rs2_i  in  1 each  ID instruction actually reads rs1/rs2
- branch_taken_i  in  1  EX resolved a taken branch/jump
- exmem_memreq_i  in  1  instruction in MEM is a load or store
- dmem_ready_i  in  1  data memory completes the access this cycle
- pc_en_o, ifid_en_o, idex_en_o, exmem_en_o  out  1 each  register load enables
- ifid_flush_o, idex_flush_o  out  1 each  load NOP into IFID/IDEX
- memwb_bubble_o  out  1  MEMWB latches RegWrite=0
- state_o  out  2  current FSM state
- err_o  out  1  sticky memory-timeout error
- stall_cnt_o  out  CNT_W  cycles with pc_en_o==0, saturating

## Operation
- **State and counters:**
  - States: RUN=0, MEM_WAIT=1, ERR=2; encoding 3 is illegal and behaves as RUN.
  - Registered: state, wait_cnt (8 bit), err, stall_cnt.
  - Outputs are combinational from state and current inputs (Mealy).
- **Load-use hazard (lu):** idex_memread_i & idex_rd_i!=0 & ((ifid_use_rs1_i & rs1==rd) | (ifid_use_rs2_i & rs2==rd)).
- **Mem stall (ms):** exmem_memreq_i & !dmem_ready_i.
- **RUN, priority ms > branch > lu > normal:**
  - ms: all four enables 0, memwb_bubble_o=1, flushes 0; next MEM_WAIT, wait_cnt=1.
  - branch_taken_i: all enables 1, ifid_flush_o=1, idex_flush_o=1 (lu ignored; ID holds a wrong-path instruction).
  - lu: pc_en_o=0, ifid_en_o=0, idex_en_o=1, idex_flush_o=1, exmem_en_o=1.
  - normal: all enables 1, no flush/bubble.
- **MEM_WAIT:**
  - dmem_ready_i=1: outputs decode as RUN with ms=0 (same-cycle release, so MEMWB captures the data); next RUN, wait_cnt=0.
  - Otherwise: freeze as above, wait_cnt+1.
  - Timeout: if wait_cnt==MEM_TIMEOUT and dmem_ready_i=0, next ERR.
- **ERR:** full freeze plus bubble; err_o=1 until reset. A late dmem_ready_i is ignored.
- **Branch during MEM_WAIT:** EX is frozen, so branch_taken_i stays asserted and is acted on in the release cycle.
- **stall_cnt:** +1 each non-reset cycle with pc_en_o==0; holds at all-ones.

## Timing
- **Zero-cycle response:** flush/enable outputs respond in the same cycle as the triggering inputs. State, wait_cnt, err and stall_cnt update on posedge clk.
- **Load-use stall:** exactly 1 cycle. The next cycle the load has moved to MEM, so lu drops.
- **MEM_WAIT duration:** N cycles of dmem_ready_i=0 freeze N cycles, then release in the ready cycle.
- **Reset (rst_n=1, any state including mid-MEM_WAIT/ERR):**
  - Same-cycle outputs: enables all 0, ifid_flush_o=idex_flush_o=memwb_bubble_o=1, state_o reflects the current state.
  - After the edge: state=RUN, wait_cnt=0, err_o=0, stall_cnt_o=0.
  - stall_cnt does not count reset cycles.

## Structure
- **Shared package `pipeline_pkg`:** state enum (RUN/MEM_WAIT/ERR), REG_ADDR_W=5, the NOP constant used by the flush logic in IFID/IDEX.
- **Sub-module `hazard_cmp`:** combinational lu detection (the x0 check plus two guarded compares), reusable by the forwarding unit.
- **Top:** FSM, wait/stall counters, output decode.

## Test plan
1. **Load-use:** idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5, use_rs1=1 → one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt_o=1.
2. **x0 and unused source:** idex_rd_i=0, or matching rs2 with use_rs2=0 → no stall.
3. **Branch overrides load-use:** branch_taken_i=1 with lu true → ifid_flush=idex_flush=1, pc_en=1.
4. **Memory wait:** exmem_memreq_i=1, dmem_ready_i low for 3 cycles then high → 3 cycles frozen with memwb_bubble=1, state_o=1; release in the 4th cycle; stall_cnt_o=3.
5. **Timeout:** MEM_TIMEOUT=4, dmem_ready_i never high → state_o=2 and err_o=1 after the 4th wait cycle; later dmem_ready_i=1 keeps ERR; rst_n=1 for one cycle → RUN, err_o=0, counters 0.
6. **Saturation:** CNT_W=4 with a 20-cycle freeze → stall_cnt_o holds at 15.
